// File: rtl/spi_reg_frame.sv
// SPI frame/command decoder: turns received bytes into burst register writes or reads
// with address auto-increment, and drives the SPI byte interface tx with status or read data.
module spi_reg_frame #(
  parameter int         ADDR_W      = 7,
  parameter logic [7:0] STATUS_BYTE = 8'hA5,
  parameter bit         AUTO_INC    = 1'b1
) (
  input  logic              sysClk,
  input  logic              usrReset,
  input  logic              SS,
  input  logic              rxValid,
  input  logic [7:0]        rx,
  output logic [7:0]        tx,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [7:0]        wr_data,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        rd_data,
  output logic              frame_active,
  output logic [7:0]        byte_cnt,
  output logic              cmd_is_read
);

  typedef enum logic [1:0] {IDLE, CMD, WRITE, READ} state_e;

  localparam logic [ADDR_W-1:0] ADDR_STEP = ADDR_W'(AUTO_INC);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        tx_q, tx_d;
  logic              wr_en_q, wr_en_d;
  logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
  logic [7:0]        wr_data_q, wr_data_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              rd_pend_q;
  logic              frame_q, frame_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              cmd_rd_q, cmd_rd_d;

  logic ss_meta_q, ss_sync_q, ss_act_prev_q;
  logic ss_act, ss_rise;
  logic [ADDR_W-1:0] rx_addr;

  // Synchronizer flops carry no reset so a held-low SS cannot fake a fresh edge after reset.
  always_ff @(posedge sysClk) begin
    ss_meta_q <= SS;
    ss_sync_q <= ss_meta_q;
  end

  // Edge-detect history resets to "active" so only a genuine high->low SS starts a frame.
  always_ff @(posedge sysClk) begin
    if (usrReset) ss_act_prev_q <= 1'b1;
    else          ss_act_prev_q <= ss_act;
  end

  assign ss_act  = ~ss_sync_q;
  assign ss_rise = ss_act & ~ss_act_prev_q;
  assign rx_addr = rx[ADDR_W-1:0];

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    tx_d      = tx_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    frame_d   = frame_q;
    cnt_d     = cnt_q;
    cmd_rd_d  = cmd_rd_q;

    if (state_q != IDLE && rxValid && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;

    case (state_q)
      IDLE: begin
        if (ss_rise) begin
          state_d = CMD;
          cnt_d   = 8'd0;
          tx_d    = STATUS_BYTE;
          frame_d = 1'b1;
        end
      end
      CMD: begin
        if (rxValid) begin
          cmd_rd_d = rx[7];
          if (rx[7]) begin
            // Prefetch the first register so it is ready for data byte 1.
            rd_en_d   = 1'b1;
            rd_addr_d = rx_addr;
            addr_d    = rx_addr + ADDR_STEP;
            state_d   = READ;
          end else begin
            addr_d  = rx_addr;
            tx_d    = 8'h00;
            state_d = WRITE;
          end
        end
      end
      WRITE: begin
        if (rxValid) begin
          wr_en_d   = 1'b1;
          wr_addr_d = addr_q;
          wr_data_d = rx;
          addr_d    = addr_q + ADDR_STEP;
        end
      end
      READ: begin
        if (rd_pend_q) tx_d = rd_data;
        if (rxValid) begin
          rd_en_d   = 1'b1;
          rd_addr_d = addr_q;
          addr_d    = addr_q + ADDR_STEP;
        end
      end
      default: state_d = IDLE;
    endcase

    // Frame end wins over everything except the strobe for a byte arriving this cycle.
    if (state_q != IDLE && !ss_act) begin
      state_d = IDLE;
      frame_d = 1'b0;
      tx_d    = STATUS_BYTE;
    end
  end

  always_ff @(posedge sysClk) begin
    if (usrReset) begin
      state_q   <= IDLE;
      addr_q    <= '0;
      tx_q      <= STATUS_BYTE;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= 8'h00;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      rd_pend_q <= 1'b0;
      frame_q   <= 1'b0;
      cnt_q     <= 8'h00;
      cmd_rd_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      addr_q    <= addr_d;
      tx_q      <= tx_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      rd_pend_q <= rd_en_q;
      frame_q   <= frame_d;
      cnt_q     <= cnt_d;
      cmd_rd_q  <= cmd_rd_d;
    end
  end

  assign tx           = tx_q;
  assign wr_en        = wr_en_q;
  assign wr_addr      = wr_addr_q;
  assign wr_data      = wr_data_q;
  assign rd_en        = rd_en_q;
  assign rd_addr      = rd_addr_q;
  assign frame_active = frame_q;
  assign byte_cnt     = cnt_q;
  assign cmd_is_read  = cmd_rd_q;

endmodule

// File: tb/tb_spi_reg_frame.sv
// Bench for spi_reg_frame: table of frames plus hand-written abort/reset/saturation sequences,
// strobes checked against a scoreboard, MISO bytes against table constants.
module tb_spi_reg_frame;

  localparam int AW = 7;

  logic          sysClk, usrReset, SS, rxValid;
  logic [7:0]    rx, rd_data;
  logic [7:0]    tx, wr_data, byte_cnt;
  logic          wr_en, rd_en, frame_active, cmd_is_read;
  logic [AW-1:0] wr_addr, rd_addr;

  logic [7:0]    tx2, wr_data2, byte_cnt2;
  logic          wr_en2, rd_en2, frame_active2, cmd_is_read2;
  logic [AW-1:0] wr_addr2, rd_addr2;

  spi_reg_frame dut (
    .sysClk(sysClk), .usrReset(usrReset), .SS(SS), .rxValid(rxValid), .rx(rx), .tx(tx),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data), .rd_en(rd_en), .rd_addr(rd_addr),
    .rd_data(rd_data), .frame_active(frame_active), .byte_cnt(byte_cnt), .cmd_is_read(cmd_is_read)
  );

  spi_reg_frame #(.AUTO_INC(1'b0)) dut_hold (
    .sysClk(sysClk), .usrReset(usrReset), .SS(SS), .rxValid(rxValid), .rx(rx), .tx(tx2),
    .wr_en(wr_en2), .wr_addr(wr_addr2), .wr_data(wr_data2), .rd_en(rd_en2), .rd_addr(rd_addr2),
    .rd_data(8'h00), .frame_active(frame_active2), .byte_cnt(byte_cnt2), .cmd_is_read(cmd_is_read2)
  );

  initial sysClk = 1'b0;
  always #5 sysClk = ~sysClk;

  // External register file: read data one cycle after rd_en.
  logic [7:0] mem [128];
  always @(posedge sysClk) begin
    if (rd_en) rd_data <= mem[rd_addr];
    if (wr_en) mem[wr_addr] <= wr_data;
  end

  int n_chk = 0;
  int n_fail = 0;
  logic [14:0]   exp_wr[$];
  logic [14:0]   exp_wr2[$];
  logic [AW-1:0] exp_rd[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Scoreboard: every strobe must match the oldest pending expectation.
  always @(negedge sysClk) begin
    if (wr_en || rd_en) chk("strobe_exclusive", {31'd0, wr_en & rd_en}, 32'd0);
    if (wr_en) begin
      if (exp_wr.size() == 0) chk("unexpected_wr", {17'd0, wr_addr, wr_data}, 32'hFFFF);
      else chk("wr_addr_data", {17'd0, wr_addr, wr_data}, {17'd0, exp_wr.pop_front()});
    end
    if (rd_en) begin
      if (exp_rd.size() == 0) chk("unexpected_rd", {25'd0, rd_addr}, 32'hFFFF);
      else chk("rd_addr", {25'd0, rd_addr}, {25'd0, exp_rd.pop_front()});
    end
    if (wr_en2) begin
      if (exp_wr2.size() == 0) chk("unexpected_wr_hold", {17'd0, wr_addr2, wr_data2}, 32'hFFFF);
      else chk("wr_hold_addr_data", {17'd0, wr_addr2, wr_data2}, {17'd0, exp_wr2.pop_front()});
    end
  end

  typedef struct packed {
    logic [7:0]      cmd;
    logic [7:0]      n;
    logic [3:0][7:0] d;
    logic [3:0][7:0] miso;  // expected tx after byte k (k=0 is the command)
    logic [7:0]      cnt;
  } frame_t;

  function automatic frame_t mk(input logic [7:0] cmd, input logic [7:0] n,
                                input logic [7:0] d0, d1, d2, d3,
                                input logic [7:0] m0, m1, m2, m3, input logic [7:0] cnt);
    frame_t f;
    f.cmd = cmd; f.n = n; f.cnt = cnt;
    f.d[0] = d0; f.d[1] = d1; f.d[2] = d2; f.d[3] = d3;
    f.miso[0] = m0; f.miso[1] = m1; f.miso[2] = m2; f.miso[3] = m3;
    return f;
  endfunction

  task automatic tick();
    @(posedge sysClk);
    #1;
  endtask

  task automatic chk_reset();
    @(negedge sysClk);
    chk("rst_tx", {24'd0, tx}, 32'hA5);
    chk("rst_wr_en", {31'd0, wr_en}, 0);
    chk("rst_rd_en", {31'd0, rd_en}, 0);
    chk("rst_wr_addr", {25'd0, wr_addr}, 0);
    chk("rst_wr_data", {24'd0, wr_data}, 0);
    chk("rst_rd_addr", {25'd0, rd_addr}, 0);
    chk("rst_frame_active", {31'd0, frame_active}, 0);
    chk("rst_byte_cnt", {24'd0, byte_cnt}, 0);
    chk("rst_cmd_is_read", {31'd0, cmd_is_read}, 0);
    chk("rst_hold_tx", {24'd0, tx2}, 32'hA5);
    chk("rst_hold_rd", {24'd0, rd_en2, rd_addr2}, 0);
  endtask

  task automatic ss_begin();
    SS = 1'b0;
    repeat (4) tick();
    @(negedge sysClk);
    chk("start_frame_active", {31'd0, frame_active}, 1);
    chk("start_byte_cnt", {24'd0, byte_cnt}, 0);
    chk("start_tx_status", {24'd0, tx}, 32'hA5);
  endtask

  task automatic ss_end();
    SS = 1'b1;
    repeat (4) tick();
    @(negedge sysClk);
    chk("end_frame_active", {31'd0, frame_active}, 0);
    chk("end_tx_status", {24'd0, tx}, 32'hA5);
  endtask

  // One byte, then tx checked two edges after the byte strobe is sampled.
  task automatic send(input logic [7:0] b, input bit do_chk, input logic [7:0] exp_tx);
    rx = b;
    rxValid = 1'b1;
    tick();
    rxValid = 1'b0;
    tick();
    tick();
    @(negedge sysClk);
    if (do_chk) chk("tx_latency", {24'd0, tx}, {24'd0, exp_tx});
    repeat (10) tick();
  endtask

  // Byte strobe lands in the same cycle the synchronized select drops.
  task automatic abort_byte(input logic [7:0] b);
    SS = 1'b1;
    tick();
    tick();
    rx = b;
    rxValid = 1'b1;
    tick();
    rxValid = 1'b0;
    repeat (4) tick();
    @(negedge sysClk);
    chk("abort_frame_active", {31'd0, frame_active}, 0);
    chk("abort_tx_status", {24'd0, tx}, 32'hA5);
  endtask

  task automatic run_frame(input frame_t f);
    logic [AW-1:0] a;
    ss_begin();
    a = f.cmd[AW-1:0];
    if (f.cmd[7]) begin
      exp_rd.push_back(a);
      for (int i = 0; i < int'(f.n); i++) begin
        a = a + 1'b1;
        exp_rd.push_back(a);
      end
    end else begin
      for (int i = 0; i < int'(f.n); i++) begin
        exp_wr.push_back({a, f.d[i]});
        exp_wr2.push_back({f.cmd[AW-1:0], f.d[i]});
        a = a + 1'b1;
      end
    end
    send(f.cmd, f.n > 0, f.miso[0]);
    for (int i = 0; i < int'(f.n); i++) send(f.d[i], (i + 1) < int'(f.n), f.miso[i+1]);
    chk("frame_byte_cnt", {24'd0, byte_cnt}, {24'd0, f.cnt});
    chk("frame_hold_byte_cnt", {24'd0, byte_cnt2}, {24'd0, f.cnt});
    chk("frame_cmd_is_read", {31'd0, cmd_is_read}, {31'd0, f.cmd[7]});
    ss_end();
    chk("held_byte_cnt", {24'd0, byte_cnt}, {24'd0, f.cnt});
    chk("held_cmd_is_read", {31'd0, cmd_is_read}, {31'd0, f.cmd[7]});
    chk("queues_drained", exp_wr.size() + exp_rd.size() + exp_wr2.size(), 0);
  endtask

  frame_t tbl [8];

  initial begin
    tbl[0] = mk(8'h05, 3, 8'h11, 8'h22, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 4);
    tbl[1] = mk(8'h10, 4, 8'hDE, 8'hAD, 8'hBE, 8'hEF, 8'h00, 8'h00, 8'h00, 8'h00, 5);
    tbl[2] = mk(8'h90, 3, 8'h00, 8'h00, 8'h00, 8'h00, 8'hDE, 8'hAD, 8'hBE, 8'h00, 4);
    tbl[3] = mk(8'h7F, 2, 8'hAA, 8'hBB, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3);
    tbl[4] = mk(8'h7E, 1, 8'h5C, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 2);
    tbl[5] = mk(8'hFE, 2, 8'h00, 8'h00, 8'h00, 8'h00, 8'h5C, 8'hAA, 8'h00, 8'h00, 3);
    tbl[6] = mk(8'h86, 1, 8'h00, 8'h00, 8'h00, 8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 2);
    tbl[7] = mk(8'h03, 2, 8'h01, 8'h02, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 3);

    usrReset = 1'b1; SS = 1'b1; rxValid = 1'b0; rx = 8'h00;
    repeat (4) tick();
    usrReset = 1'b0;
    chk_reset();

    for (int i = 0; i < 8; i++) run_frame(tbl[i]);

    // Abort after a read command: only the prefetch, then status.
    ss_begin();
    exp_rd.push_back(7'h05);
    send(8'h85, 1'b1, 8'h11);
    ss_end();
    chk("abort_byte_cnt", {24'd0, byte_cnt}, 1);
    chk("abort_cmd_is_read", {31'd0, cmd_is_read}, 1);
    send(8'h42, 1'b1, 8'hA5);
    chk("idle_byte_cnt", {24'd0, byte_cnt}, 1);

    // Data byte coinciding with the select dropping, read then write.
    ss_begin();
    exp_rd.push_back(7'h04);
    exp_rd.push_back(7'h05);
    send(8'h84, 1'b1, 8'h02);
    abort_byte(8'h00);
    chk("coinc_rd_byte_cnt", {24'd0, byte_cnt}, 2);
    ss_begin();
    exp_wr.push_back({7'h0A, 8'h77});
    exp_wr2.push_back({7'h0A, 8'h77});
    send(8'h0A, 1'b1, 8'h00);
    abort_byte(8'h77);
    chk("coinc_wr_byte_cnt", {24'd0, byte_cnt}, 2);
    chk("coinc_queues", exp_wr.size() + exp_rd.size() + exp_wr2.size(), 0);

    // Reset mid-write with the select still low.
    ss_begin();
    exp_wr.push_back({7'h20, 8'h44});
    exp_wr2.push_back({7'h20, 8'h44});
    send(8'h20, 1'b1, 8'h00);
    send(8'h44, 1'b0, 8'h00);
    usrReset = 1'b1;
    tick();
    tick();
    usrReset = 1'b0;
    chk_reset();
    send(8'h55, 1'b1, 8'hA5);
    chk("post_rst_frame_active", {31'd0, frame_active}, 0);
    chk("post_rst_byte_cnt", {24'd0, byte_cnt}, 0);
    SS = 1'b1;
    repeat (4) tick();
    ss_begin();
    exp_wr.push_back({7'h30, 8'h66});
    exp_wr2.push_back({7'h30, 8'h66});
    send(8'h30, 1'b1, 8'h00);
    send(8'h66, 1'b0, 8'h00);
    chk("post_rst_frame_cnt", {24'd0, byte_cnt}, 2);
    ss_end();

    // Long write burst: byte_cnt saturates, address wraps.
    ss_begin();
    send(8'h40, 1'b1, 8'h00);
    for (int i = 0; i < 300; i++) begin
      exp_wr.push_back({7'(7'h40 + i), 8'(i)});
      exp_wr2.push_back({7'h40, 8'(i)});
      rx = 8'(i);
      rxValid = 1'b1;
      tick();
      rxValid = 1'b0;
      tick();
    end
    repeat (4) tick();
    @(negedge sysClk);
    chk("sat_byte_cnt", {24'd0, byte_cnt}, 32'hFF);
    ss_end();
    chk("sat_queues", exp_wr.size() + exp_rd.size() + exp_wr2.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/spi_reg_frame.md
Name: spi_reg_frame

Overview:
- Frame/command decoder directly downstream of the SPI byte interface (SPI mode 3 slave).
- Consumes the received byte strobe and byte. Decodes a command byte, then issues burst writes to or reads from an external byte-wide register file with address auto-increment.
- Drives the byte-to-transmit input of the SPI byte interface so the master receives read data on MISO.

Parameters:
ADDR_W, 7, register address width; 1..7; the address field is cmd[ADDR_W-1:0], and cmd[6:ADDR_W] is ignored
STATUS_BYTE, 8'hA5, byte returned on MISO during the command byte of every frame
AUTO_INC, 1, 1 = address increments after each data byte; 0 = address is held for the whole frame

Ports:
sysClk  in  1  system clock, single clock domain
usrReset  in  1  synchronous reset, active-high
SS  in  1  raw SPI slave select, active-low, asynchronous; synchronized internally
rxValid  in  1  one-cycle strobe: rx holds a complete received byte
rx  in  8  received byte
tx  out  8  byte to transmit; feeds the SPI byte interface tx input
wr_en  out  1  one-cycle register write strobe
wr_addr  out  ADDR_W  write address
wr_data  out  8  write data
rd_en  out  1  one-cycle register read strobe
rd_addr  out  ADDR_W  read address
rd_data  in  8  read data, valid exactly 1 cycle after rd_en
frame_active  out  1  high while the synchronized SS is low
byte_cnt  out  8  bytes received in the current frame, saturates at 8'hFF
cmd_is_read  out  1  latched bit 7 of the current frame's command byte

Behaviour:
- Clock and reset: all logic on posedge sysClk. usrReset is synchronous and active-high.
- Reset values: state=IDLE, tx=STATUS_BYTE, wr_en=0, rd_en=0, wr_addr=0, wr_data=0, rd_addr=0, frame_active=0, byte_cnt=0, cmd_is_read=0, internal address=0.
- SS synchronization: two-flop synchronizer followed by an edge-detect flop. ss_act is the inverted synchronized SS.
- Frame protocol:
  - Byte 0 is the command: bit7 = 1 for read, 0 for write; bits[ADDR_W-1:0] = start address.
  - Bytes 1..n are data.
- State machine: IDLE, CMD, WRITE, READ.
  - IDLE -> CMD on the ss_act rising edge. Same cycle: byte_cnt<=0, tx<=STATUS_BYTE, frame_active<=1.
  - CMD, on rxValid: latch address and cmd_is_read; byte_cnt<=1. If bit7=0 go to WRITE. If bit7=1 go to READ and assert rd_en with rd_addr=address on the next cycle.
  - WRITE, on rxValid (cycle T):
    - At T+1: wr_en=1, wr_addr=address, wr_data=rx.
    - Address increments (if AUTO_INC) at T+1.
    - tx<=8'h00 for the whole WRITE frame.
  - READ, for the command byte at T:
    - rd_en at T+1.
    - tx<=rd_data at T+2.
    - Address then increments (if AUTO_INC).
  - READ, on each data-byte rxValid at T: same rd_en/tx sequence, prefetching the next byte for the next transfer.
    - Net: the master receives reg[a], reg[a+1], ... on data bytes 1, 2, ...
    - The data received on MOSI is ignored.
  - Any state -> IDLE when ss_act is low. On that transition: frame_active<=0, tx<=STATUS_BYTE. byte_cnt and cmd_is_read hold their values until the next frame.
- Latency:
  - rxValid to tx update: 2 cycles maximum.
  - Integration constraint: sysClk >= 8x SCLK, so tx is stable before the next SCLK falling edge.
- Address arithmetic: modulo 2^ADDR_W. With AUTO_INC, address (2^ADDR_W)-1 is followed by 0.
- byte_cnt increments on every rxValid while in a frame and saturates at 255 (no wrap).
- wr_en and rd_en are never high together, and each is at most one cycle per received byte.
- Boundary conditions:
  - rxValid in the same cycle that ss_act falls: the byte is processed (write or read issued) and the state then goes to IDLE.
  - A pending rd_en or wr_en completes. tx is then forced to STATUS_BYTE.
  - rxValid while in IDLE: ignored; no strobes issued.
  - Frame containing only a command byte: no wr_en. For a read command one rd_en is issued (harmless prefetch).
  - usrReset mid-frame: all outputs return to reset values on the next edge. The state stays IDLE until a fresh ss_act rising edge, even if SS is still low.
  - ss_act falling then rising with no bytes in between: a new frame starts with byte_cnt=0.

Test Plan:
- Write burst. Frame 0x05, 0x11, 0x22, 0x33 -> wr_en pulses with (addr, data) = (5, 0x11), (6, 0x22), (7, 0x33); no rd_en; byte_cnt=4; tx=0x00 during the data bytes.
- Read burst. Preload reg[0x10..0x12] = 0xDE, 0xAD, 0xBE; frame 0x90 plus 3 dummy bytes -> MISO returns 0xA5, 0xDE, 0xAD, 0xBE; rd_addr sequence is 0x10, 0x11, 0x12, 0x13; cmd_is_read=1.
- Address wrap. Write 0x7F, 0xAA, 0xBB with ADDR_W=7 -> writes (0x7F, 0xAA) then (0x00, 0xBB).
- AUTO_INC=0. Write 0x03, 0x01, 0x02 -> two wr_en pulses, both with addr 3.
- Abort and reset. Deassert SS after the command byte 0x85 -> state IDLE, no further strobes, tx=0xA5. Assert usrReset mid-write with SS still low -> all outputs at reset values; subsequent rxValid is ignored until SS toggles high then low.
- Latency check. SCLK = sysClk/8 -> tx updated no later than 2 cycles after each rxValid, and the correct MSB appears on MISO at the first falling edge of the next byte.
